// File: rtl/compresscore_ctrl_pkg.sv
// Shared definitions for the compress core control/status register block:
// register offsets, STATUS bit positions, AXI response codes and FSM states.
package compresscore_ctrl_pkg;

    localparam logic [4:0] CTRL_OFS     = 5'h00;
    localparam logic [4:0] SRC_LEN_OFS  = 5'h04;
    localparam logic [4:0] DST_ADDR_OFS = 5'h08;
    localparam logic [4:0] CFG_OFS      = 5'h0C;
    localparam logic [4:0] STATUS_OFS   = 5'h10;
    localparam logic [4:0] OUT_LEN_OFS  = 5'h14;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_REJECTED = 2;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Word slots 0..5 decode to registers; 6 and 7 are holes in the map.
    function automatic logic slot_mapped(input logic [2:0] slot);
        return slot <= STATUS_OFS[4:2] + 3'd1;
    endfunction

endpackage

// File: rtl/compresscore_ctrl_axil_slave.sv
// AXI4-Lite responder for the compress core register file: independent read
// and write channel FSMs, byte-lane RW registers, sticky W1C status, start pulse.
//
// state  | meaning
// W_IDLE | collecting AW and W independently; commit when both are held
// W_RESP | write committed, BVALID held until BREADY
// R_IDLE | ARREADY high; AR handshake latches read payload
// R_DATA | RVALID held until RREADY
module compresscore_ctrl_axil_slave
    import compresscore_ctrl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     core_ctrl,
    output logic [31:0]                     core_src_len,
    output logic [31:0]                     core_dst_addr,
    output logic [31:0]                     core_cfg,
    output logic                            core_start,
    input  logic                            core_busy,
    input  logic                            core_done,
    input  logic [31:0]                     core_out_len
);

    localparam logic [2:0] CTRL_SLOT     = CTRL_OFS[4:2];
    localparam logic [2:0] SRC_LEN_SLOT  = SRC_LEN_OFS[4:2];
    localparam logic [2:0] DST_ADDR_SLOT = DST_ADDR_OFS[4:2];
    localparam logic [2:0] CFG_SLOT      = CFG_OFS[4:2];
    localparam logic [2:0] STATUS_SLOT   = STATUS_OFS[4:2];
    localparam logic [2:0] OUT_LEN_SLOT  = OUT_LEN_OFS[4:2];

    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic        aw_got, w_got;
    logic [2:0]  aw_slot_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    axi_resp_t   bresp_q, rresp_q;
    logic [31:0] rdata_q, rd_mux;
    logic        aw_hs, w_hs, w_commit;
    logic [2:0]  wr_slot, rd_slot;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        sts_done, sts_rej;
    logic [31:0] out_len;
    logic        start_req, w1c_done, w1c_rej;
    logic        unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        w_next        = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        w_commit      = 1'b0;
        case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = !aw_got;
                S_AXI_WREADY  = !w_got;
                if ((aw_got || S_AXI_AWVALID) && (w_got || S_AXI_WVALID)) begin
                    w_commit = 1'b1;
                    w_next   = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
    // A channel completing on the commit edge is used directly, not via its holding register.
    assign wr_slot = aw_got ? aw_slot_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_data = w_got ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_got ? wstrb_q : S_AXI_WSTRB;
    assign S_AXI_BRESP = bresp_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state   <= W_IDLE;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_slot_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            if (w_commit) begin
                aw_got  <= 1'b0;
                w_got   <= 1'b0;
                bresp_q <= slot_mapped(wr_slot) ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_got    <= 1'b1;
                    aw_slot_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_got   <= 1'b1;
                    wdata_q <= S_AXI_WDATA;
                    wstrb_q <= S_AXI_WSTRB;
                end
            end
        end
    end

    always_comb begin
        r_next        = r_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (r_state)
            R_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) r_next = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign rd_slot = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    always_comb begin
        rd_mux = '0;
        case (rd_slot)
            CTRL_SLOT:     rd_mux = core_ctrl;
            SRC_LEN_SLOT:  rd_mux = core_src_len;
            DST_ADDR_SLOT: rd_mux = core_dst_addr;
            CFG_SLOT:      rd_mux = core_cfg;
            STATUS_SLOT:   rd_mux = {29'd0, sts_rej, sts_done, core_busy};
            OUT_LEN_SLOT:  rd_mux = out_len;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                rdata_q <= rd_mux;
                rresp_q <= slot_mapped(rd_slot) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;

    assign start_req = w_commit && (wr_slot == CTRL_SLOT) && wr_strb[0] && wr_data[0];
    assign w1c_done  = w_commit && (wr_slot == STATUS_SLOT) && wr_strb[0] && wr_data[ST_DONE];
    assign w1c_rej   = w_commit && (wr_slot == STATUS_SLOT) && wr_strb[0] && wr_data[ST_REJECTED];

    // Sticky set terms are OR'd after the clear so a coincident event wins over W1C.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            core_ctrl     <= '0;
            core_src_len  <= '0;
            core_dst_addr <= '0;
            core_cfg      <= '0;
            core_start    <= 1'b0;
            sts_done      <= 1'b0;
            sts_rej       <= 1'b0;
            out_len       <= '0;
        end else begin
            if (w_commit) begin
                case (wr_slot)
                    CTRL_SLOT:     core_ctrl     <= apply_strb(core_ctrl, wr_data, wr_strb);
                    SRC_LEN_SLOT:  core_src_len  <= apply_strb(core_src_len, wr_data, wr_strb);
                    DST_ADDR_SLOT: core_dst_addr <= apply_strb(core_dst_addr, wr_data, wr_strb);
                    CFG_SLOT:      core_cfg      <= apply_strb(core_cfg, wr_data, wr_strb);
                    default: ;
                endcase
            end
            core_start <= start_req && !core_busy;
            sts_done   <= core_done || (sts_done && !w1c_done);
            sts_rej    <= (start_req && core_busy) || (sts_rej && !w1c_rej);
            if (core_done) out_len <= core_out_len;
        end
    end

endmodule

// File: tb/tb_compresscore_ctrl_axil_slave.sv
// Self-checking bench for compresscore_ctrl_axil_slave: vector table, directed
// multi-cycle corner cases, and randomized traffic against a register-map model.
module tb_compresscore_ctrl_axil_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [31:0] core_ctrl, core_src_len, core_dst_addr, core_cfg, core_out_len;
    logic        core_start, core_busy, core_done;

    always #5 clk = ~clk;

    compresscore_ctrl_axil_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .core_ctrl(core_ctrl), .core_src_len(core_src_len), .core_dst_addr(core_dst_addr),
        .core_cfg(core_cfg), .core_start(core_start), .core_busy(core_busy),
        .core_done(core_done), .core_out_len(core_out_len)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    bit start_wide = 1'b0;
    bit prev_start = 1'b0;

    always @(negedge clk) begin
        if (core_start) start_cnt++;
        if (core_start && prev_start) start_wide = 1'b1;
        prev_start = core_start;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        bit aw_done, w_done;
        logic aw_r, w_r;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_r = awready; w_r = wready;
            tick();
            if (aw_r && awvalid) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_r && wvalid)   begin w_done = 1'b1;  wvalid = 1'b0;  end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        if (!bvalid) begin
            check("write_timeout", 32'(bvalid), 32'd1);
            resp = 2'b11;
        end else begin
            resp = bresp;
            bready = 1'b1;
            tick();
            bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        logic ar_r;
        araddr = a; arvalid = 1'b1; n = 0;
        while (n < 50) begin
            ar_r = arready;
            tick();
            n++;
            if (ar_r) break;
        end
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        if (!rvalid) begin
            check("read_timeout", 32'(rvalid), 32'd1);
            d = 32'hxxxxxxxx; resp = 2'b11;
        end else begin
            d = rdata; resp = rresp;
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[16];

    logic [31:0] mdl_rw[4];
    logic        mdl_done, mdl_rej;
    logic [31:0] mdl_out_len;

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        int          snap, exp_starts, base;
        bit          b_ok, r_ok;
        logic [5:0]  pattern;

        vecs[0]  = '{1'b1, 5'h00, 32'd1, 4'hF, 32'd0, 2'b00};
        vecs[1]  = '{1'b1, 5'h04, 32'd2, 4'hF, 32'd0, 2'b00};
        vecs[2]  = '{1'b1, 5'h08, 32'd3, 4'hF, 32'd0, 2'b00};
        vecs[3]  = '{1'b1, 5'h0C, 32'd4, 4'hF, 32'd0, 2'b00};
        vecs[4]  = '{1'b0, 5'h00, 32'd0, 4'h0, 32'd1, 2'b00};
        vecs[5]  = '{1'b0, 5'h04, 32'd0, 4'h0, 32'd2, 2'b00};
        vecs[6]  = '{1'b0, 5'h08, 32'd0, 4'h0, 32'd3, 2'b00};
        vecs[7]  = '{1'b0, 5'h0C, 32'd0, 4'h0, 32'd4, 2'b00};
        vecs[8]  = '{1'b0, 5'h10, 32'd0, 4'h0, 32'd0, 2'b00};
        vecs[9]  = '{1'b0, 5'h14, 32'd0, 4'h0, 32'd0, 2'b00};
        vecs[10] = '{1'b0, 5'h18, 32'd0, 4'h0, 32'd0, 2'b10};
        vecs[11] = '{1'b1, 5'h1C, 32'hFFFFFFFF, 4'hF, 32'd0, 2'b10};
        vecs[12] = '{1'b0, 5'h00, 32'd0, 4'h0, 32'd1, 2'b00};
        vecs[13] = '{1'b0, 5'h0C, 32'd0, 4'h0, 32'd4, 2'b00};
        vecs[14] = '{1'b0, 5'h1C, 32'd0, 4'h0, 32'd0, 2'b10};
        vecs[15] = '{1'b0, 5'h06, 32'd0, 4'h0, 32'd2, 2'b00};

        rst = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0;
        core_busy = 1'b0; core_done = 1'b0; core_out_len = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_start", 32'(core_start), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ctrl", core_ctrl, 32'd0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
            end else begin
                axi_read(vecs[i].addr, d, resp);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
            end
        end
        check("vec_start_count", 32'(start_cnt), 32'd1);
        check("vec_core_src_len", core_src_len, 32'd2);
        check("vec_core_dst_addr", core_dst_addr, 32'd3);
        check("vec_core_cfg", core_cfg, 32'd4);

        // W arrives two cycles ahead of AW.
        axi_write(5'h08, 32'd0, 4'hF, resp);
        wdata = 32'hA5A5A5A5; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("wfirst_wready_low", 32'(wready), 32'd0);
        check("wfirst_no_bvalid", 32'(bvalid), 32'd0);
        tick();
        awaddr = 5'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst_bvalid", 32'(bvalid), 32'd1);
        check("wfirst_dst_addr", core_dst_addr, 32'h00A500A5);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("wfirst_bvalid_drop", 32'(bvalid), 32'd0);

        // Back-to-back start writes with all readies held high.
        awaddr = 5'h00; wdata = 32'd1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            pattern[i] = core_start;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        check("b2b_start_pattern", 32'(pattern), 32'h15);

        // Start while busy is rejected.
        core_busy = 1'b1;
        snap = start_cnt;
        axi_write(5'h00, 32'd1, 4'hF, resp);
        check("busy_bresp", 32'(resp), 32'd0);
        check("busy_no_start", 32'(start_cnt), 32'(snap));
        axi_read(5'h10, d, resp);
        check("busy_status", d, 32'h5);
        axi_write(5'h10, 32'h4, 4'hF, resp);
        check("w1c_rej_bresp", 32'(resp), 32'd0);
        axi_read(5'h10, d, resp);
        check("w1c_rej_status", d, 32'h1);
        core_busy = 1'b0;

        // Done capture, then done coinciding with a W1C clear.
        core_out_len = 32'h1234; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        axi_read(5'h10, d, resp);
        check("done_status", d, 32'h2);
        axi_read(5'h14, d, resp);
        check("done_out_len", d, 32'h1234);
        awaddr = 5'h10; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        core_done = 1'b1; core_out_len = 32'h5678;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; core_done = 1'b0;
        check("done_w1c_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read(5'h10, d, resp);
        check("done_set_wins", d, 32'h2);
        axi_read(5'h14, d, resp);
        check("done_out_len2", d, 32'h5678);
        axi_write(5'h10, 32'h2, 4'h1, resp);
        axi_read(5'h10, d, resp);
        check("done_cleared", d, 32'h0);

        // Backpressure on both responses, same-cycle read/write of SRC_LEN, then reset.
        awaddr = 5'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h04; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        b_ok = 1'b1; r_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bvalid !== 1'b1 || bresp !== 2'b00) b_ok = 1'b0;
            if (rvalid !== 1'b1 || rresp !== 2'b00 || rdata !== 32'd2) r_ok = 1'b0;
            tick();
        end
        check("bp_b_hold", 32'(b_ok), 32'd1);
        check("bp_r_hold_old_value", 32'(r_ok), 32'd1);
        check("bp_src_len", core_src_len, 32'hDEADBEEF);
        rst = 1'b1;
        tick();
        check("midrst_bvalid", 32'(bvalid), 32'd0);
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        check("midrst_src_len", core_src_len, 32'd0);
        check("midrst_ctrl", core_ctrl, 32'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            axi_read(5'(i * 4), d, resp);
            check($sformatf("postrst_reg%0d", i), d, 32'd0);
        end

        // Randomized traffic against the register-map model.
        for (int i = 0; i < 4; i++) mdl_rw[i] = '0;
        mdl_done = 1'b0; mdl_rej = 1'b0; mdl_out_len = '0;
        exp_starts = 0;
        base = start_cnt;
        for (int i = 0; i < 120; i++) begin
            logic [2:0]  slot;
            logic [4:0]  addr;
            logic [31:0] v, exp_d;
            logic [3:0]  s;
            slot = 3'($urandom_range(0, 7));
            addr = {slot, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) begin
                v = $urandom;
                core_out_len = v; core_done = 1'b1;
                tick();
                core_done = 1'b0;
                mdl_done = 1'b1; mdl_out_len = v;
            end
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(addr, v, s, resp);
                check($sformatf("rnd%0d_bresp", i), 32'(resp), (slot >= 3'd6) ? 32'd2 : 32'd0);
                if (slot < 3'd4) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mdl_rw[slot[1:0]][8*b +: 8] = v[8*b +: 8];
                    if (slot == 3'd0 && s[0] && v[0]) exp_starts++;
                end else if (slot == 3'd4 && s[0]) begin
                    if (v[1]) mdl_done = 1'b0;
                    if (v[2]) mdl_rej = 1'b0;
                end
            end else begin
                axi_read(addr, d, resp);
                case (slot)
                    3'd0, 3'd1, 3'd2, 3'd3: exp_d = mdl_rw[slot[1:0]];
                    3'd4:    exp_d = {29'd0, mdl_rej, mdl_done, 1'b0};
                    3'd5:    exp_d = mdl_out_len;
                    default: exp_d = 32'd0;
                endcase
                check($sformatf("rnd%0d_rdata", i), d, exp_d);
                check($sformatf("rnd%0d_rresp", i), 32'(resp), (slot >= 3'd6) ? 32'd2 : 32'd0);
            end
        end
        check("rnd_start_count", 32'(start_cnt - base), 32'(exp_starts));
        check("rnd_core_ctrl", core_ctrl, mdl_rw[0]);
        check("rnd_core_cfg", core_cfg, mdl_rw[3]);
        check("start_single_cycle", 32'(start_wide), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/compresscore_ctrl_axil_slave.md
# compresscore_ctrl_axil_slave

AXI4-Lite responder holding the control/status register file of the compress core. It accepts register traffic from the host-side AXI master (VIP master in simulation, PS/interconnect in hardware). It drives the core's configuration outputs and a one-cycle start pulse, and reports core status back through read-only registers.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; covers 8 word slots.
- S_AXI_ACLK  in  1  single clock for all logic.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID  in  5/3/1  write address channel; AWPROT is ignored.
- S_AXI_AWREADY  out  1  write address channel ready.
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1  write data channel.
- S_AXI_WREADY  out  1  write data channel ready.
- S_AXI_BRESP/BVALID  out  2/1  write response.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR/ARPROT/ARVALID  in  5/3/1  read address channel; ARPROT is ignored.
- S_AXI_ARREADY  out  1  read address channel ready.
- S_AXI_RDATA/RRESP/RVALID  out  32/2/1  read data channel.
- S_AXI_RREADY  in  1  read data ready.
- core_ctrl, core_src_len, core_dst_addr, core_cfg  out  32 each  live register values.
- core_start  out  1  one-cycle start pulse.
- core_busy  in  1  core is busy (level).
- core_done  in  1  job complete (pulse).
- core_out_len  in  32  compressed length; valid when core_done is high.

## Operation
- Register map (word offsets; ADDR[1:0] is ignored):
  - 0x00 CTRL: RW.
  - 0x04 SRC_LEN: RW.
  - 0x08 DST_ADDR: RW.
  - 0x0C CFG: RW.
  - 0x10 STATUS: RO, except W1C bits. bit0 = busy (live), bit1 = done (sticky, W1C), bit2 = start_rejected (sticky, W1C).
  - 0x14 OUT_LEN: RO. Captured on core_done.
  - 0x18 and 0x1C: unmapped.
- RW registers are updated per byte lane according to WSTRB. Every written value reads back unmodified, including CTRL bit0.
- Writes to RO bits are ignored. A write to an unmapped slot changes nothing and returns BRESP = SLVERR (2'b10).
- A read from an unmapped slot returns RDATA = 0 and RRESP = SLVERR. All other accesses return OKAY.
- Start:
  - A committed CTRL write with WSTRB[0] = 1 and WDATA[0] = 1, while core_busy = 0, produces core_start = 1 in the following cycle.
  - The same write while core_busy = 1 produces no pulse and sets start_rejected.
- Write FSM states:
  - W_IDLE: AWREADY = 1 and WREADY = 1. Each channel is captured independently; a captured channel drops its own READY.
  - W_RESP: entered on the edge where the second of AW/W completes (or both complete in the same cycle). The register commit happens on that same edge. BVALID = 1, AWREADY = 0, WREADY = 0. Returns to W_IDLE on the BREADY handshake.
- Read FSM states:
  - R_IDLE: ARREADY = 1. An AR handshake latches RDATA/RRESP from the register state at that edge.
  - R_DATA: RVALID = 1, ARREADY = 0. Returns to R_IDLE on the RREADY handshake.
- The read and write FSMs are fully independent. A read and a write to the same register in the same cycle returns the old value.
- Sticky bit precedence: when core_done (or a rejected start) coincides with a W1C write, set wins.

## Timing
- Reset values:
  - All registers are 0.
  - AWREADY, WREADY and ARREADY are 1 from the first cycle after reset deasserts.
  - BVALID, RVALID and core_start are 0; BRESP, RRESP and RDATA are 0.
- Write latency: BVALID rises 1 cycle after the completing handshake; registers are visible on the core_* outputs in that same cycle.
- Read latency: RVALID rises 1 cycle after the AR handshake.
- Throughput with READY held high: one write per 2 cycles and one read per 2 cycles.
- BVALID and RVALID, together with their payloads, hold stable until their respective handshake. Backpressure of any length is legal.
- Reset mid-transaction: captured AW/W state is discarded and pending B/R responses are dropped. Outputs take their reset values on the next edge.
- core_start is never wider than 1 cycle. Back-to-back start writes produce separate pulses 2 cycles apart.

## Structure
- compresscore_ctrl_pkg holds:
  - register offset localparams (CTRL_OFS through OUT_LEN_OFS);
  - STATUS bit indices;
  - the axi_resp_t enum (OKAY, SLVERR);
  - the w_state_t and r_state_t enums.
- Single module with no sub-module. The two FSMs and the register file live in separate always_ff blocks.

## Test plan
- Write 1, 2, 3, 4 to 0x00, 0x04, 0x08, 0x0C, then read them back -> each read returns its written value with OKAY, and core_start pulses exactly once after the first write.
- Present W two cycles before AW (value 0xA5A5A5A5, WSTRB = 4'b0101, to 0x08, prior value 0) -> DST_ADDR = 0x00A500A5; BVALID rises 1 cycle after the AW handshake.
- Hold core_busy = 1 and write 1 to CTRL -> no core_start pulse; STATUS reads 0x5. Then write 0x4 to STATUS -> STATUS reads 0x1.
- Pulse core_done with core_out_len = 0x1234 -> STATUS bit1 = 1 and OUT_LEN = 0x1234. A W1C write of 0x2 in the same cycle as a second done pulse -> bit1 remains 1.
- Read 0x18 and write 0x1C -> RRESP = SLVERR with RDATA = 0, and BRESP = SLVERR with no register changed.
- Hold BREADY/RREADY low for 10 cycles, then assert reset mid-response -> payloads stay stable during backpressure; after reset, BVALID = RVALID = 0 and all registers read 0.
